// File: rtl/mips_pkg.sv
// mips_pkg
// Shared constants for the MIPS decode stage: datapath widths, the opcodes
// recognised by the main control decoder, bit positions inside the 9-bit
// control bundle and the ALUOp encodings handed on to the execute stage.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int NREGS  = 32;
  localparam int CTL_W  = 9;

  typedef logic [CTL_W-1:0] ctl_t;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_BEQ   = 6'h04,
    OP_ADDI  = 6'h08,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_e;

  // Bit positions inside controlUnitSig
  localparam int CTL_REGDST    = 8;
  localparam int CTL_ALUSRC    = 7;
  localparam int CTL_MEMTOREG  = 6;
  localparam int CTL_REGWRITE  = 5;
  localparam int CTL_MEMREAD   = 4;
  localparam int CTL_MEMWRITE  = 3;
  localparam int CTL_BRANCH    = 2;
  localparam int CTL_ALUOP_MSB = 1;
  localparam int CTL_ALUOP_LSB = 0;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

endpackage

// File: rtl/mips_decode_stage_if.sv
// mips_decode_stage_if
// Bus between the fetch/write-back side (master) and the decode stage (slave).
//   master drives : instruction, writeToReg, writeSig, finRD
//   slave drives  : signExtend, register1, register2, controlUnitSig,
//                   rd, rt, rs, shmnt, funcBits, opcode
interface mips_decode_stage_if;
  import mips_pkg::*;

  logic [DATA_W-1:0] instruction;
  logic [DATA_W-1:0] writeToReg;
  logic              writeSig;
  logic [REG_AW-1:0] finRD;

  logic [DATA_W-1:0] signExtend;
  logic [DATA_W-1:0] register1;
  logic [DATA_W-1:0] register2;
  ctl_t              controlUnitSig;
  logic [4:0]        rd;
  logic [4:0]        rt;
  logic [4:0]        rs;
  logic [4:0]        shmnt;
  logic [5:0]        funcBits;
  logic [5:0]        opcode;

  modport master (
    output instruction, writeToReg, writeSig, finRD,
    input  signExtend, register1, register2, controlUnitSig,
           rd, rt, rs, shmnt, funcBits, opcode
  );

  modport slave (
    input  instruction, writeToReg, writeSig, finRD,
    output signExtend, register1, register2, controlUnitSig,
           rd, rt, rs, shmnt, funcBits, opcode
  );

endinterface

// File: rtl/mips_reg_file.sv
// mips_reg_file
// 32 x 32-bit register file: two asynchronous read ports, one write port
// committed on the rising clock edge, R0 hardwired to zero, and an
// asynchronous active-low clear of every entry.
//   Clk, Rst_n          clock / async active-low clear
//   rd_addr1, rd_addr2  read indices      -> rd_data1, rd_data2
//   wr_en, wr_addr,     write enable, index and data
//   wr_data
module mips_reg_file
  import mips_pkg::*;
(
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [REG_AW-1:0] rd_addr1,
  input  logic [REG_AW-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] regs [NREGS];

  // Reset takes priority, so a write presented while Rst_n is low is lost.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Reads see only committed state; there is deliberately no write bypass.
  assign rd_data1 = (rd_addr1 == '0) ? '0 : regs[rd_addr1];
  assign rd_data2 = (rd_addr2 == '0) ? '0 : regs[rd_addr2];

endmodule

// File: rtl/mips_decode_stage.sv
// mips_decode_stage
// MIPS instruction-decode stage. Every rising Clk the fetched instruction is
// split into its fields and registered; register-file reads, main control
// decode and immediate sign extension are combinational from those fields.
// The write-back stage commits results through the register-file write port.
//   Clk    rising-edge clock
//   Rst_n  asynchronous active-low reset (fields and all registers clear)
//   dec    slave side of mips_decode_stage_if (instruction / write-back in,
//          decoded fields, register operands, control bundle out)
module mips_decode_stage
  import mips_pkg::*;
(
  input  logic               Clk,
  input  logic               Rst_n,
  mips_decode_stage_if.slave dec
);

  logic        [5:0]  opcode_p1;
  logic        [5:0]  funcBits_p1;
  logic        [4:0]  rs_p1;
  logic        [4:0]  rt_p1;
  logic        [4:0]  rd_p1;
  logic        [4:0]  shmnt_p1;
  logic signed [15:0] imm_p1;

  logic [DATA_W-1:0] rf_data1;
  logic [DATA_W-1:0] rf_data2;
  ctl_t              ctl_p1;

  function automatic logic signed [DATA_W-1:0] sign_ext(input logic signed [15:0] v);
    return DATA_W'(v);
  endfunction

  // ---- fetch -> decode boundary (p0 -> p1) ----
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      opcode_p1   <= '0;
      funcBits_p1 <= '0;
      rs_p1       <= '0;
      rt_p1       <= '0;
      rd_p1       <= '0;
      shmnt_p1    <= '0;
      imm_p1      <= '0;
    end else begin
      opcode_p1   <= dec.instruction[31:26];
      rs_p1       <= dec.instruction[25:21];
      rt_p1       <= dec.instruction[20:16];
      rd_p1       <= dec.instruction[15:11];
      shmnt_p1    <= dec.instruction[10:6];
      funcBits_p1 <= dec.instruction[5:0];
      imm_p1      <= dec.instruction[15:0];
    end
  end

  always_comb begin
    ctl_p1 = '0;
    case (opcode_p1)
      OP_RTYPE: begin
        ctl_p1[CTL_REGDST]                    = 1'b1;
        ctl_p1[CTL_REGWRITE]                  = 1'b1;
        ctl_p1[CTL_ALUOP_MSB:CTL_ALUOP_LSB]   = ALUOP_FUNC;
      end
      OP_LW: begin
        ctl_p1[CTL_ALUSRC]                    = 1'b1;
        ctl_p1[CTL_MEMTOREG]                  = 1'b1;
        ctl_p1[CTL_REGWRITE]                  = 1'b1;
        ctl_p1[CTL_MEMREAD]                   = 1'b1;
        ctl_p1[CTL_ALUOP_MSB:CTL_ALUOP_LSB]   = ALUOP_ADD;
      end
      OP_SW: begin
        ctl_p1[CTL_ALUSRC]                    = 1'b1;
        ctl_p1[CTL_MEMWRITE]                  = 1'b1;
        ctl_p1[CTL_ALUOP_MSB:CTL_ALUOP_LSB]   = ALUOP_ADD;
      end
      OP_BEQ: begin
        ctl_p1[CTL_BRANCH]                    = 1'b1;
        ctl_p1[CTL_ALUOP_MSB:CTL_ALUOP_LSB]   = ALUOP_SUB;
      end
      OP_ADDI: begin
        ctl_p1[CTL_ALUSRC]                    = 1'b1;
        ctl_p1[CTL_REGWRITE]                  = 1'b1;
        ctl_p1[CTL_ALUOP_MSB:CTL_ALUOP_LSB]   = ALUOP_ADD;
      end
      default: ctl_p1 = '0;
    endcase
  end

  mips_reg_file u_rf (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .rd_addr1 (rs_p1),
    .rd_addr2 (rt_p1),
    .rd_data1 (rf_data1),
    .rd_data2 (rf_data2),
    .wr_en    (dec.writeSig),
    .wr_addr  (dec.finRD),
    .wr_data  (dec.writeToReg)
  );

  assign dec.opcode         = opcode_p1;
  assign dec.funcBits       = funcBits_p1;
  assign dec.rs             = rs_p1;
  assign dec.rt             = rt_p1;
  assign dec.rd             = rd_p1;
  assign dec.shmnt          = shmnt_p1;
  assign dec.signExtend     = sign_ext(imm_p1);
  assign dec.register1      = rf_data1;
  assign dec.register2      = rf_data2;
  assign dec.controlUnitSig = ctl_p1;

endmodule

// File: tb/tb_mips_decode_stage.sv
// tb_mips_decode_stage
// Self-checking bench for mips_decode_stage: directed scenarios followed by
// randomized traffic compared against an array-based reference model.
module tb_mips_decode_stage;

  logic Clk = 1'b0;
  logic Rst_n;
  always #5 Clk = ~Clk;

  mips_decode_stage_if dec_if ();

  mips_decode_stage dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .dec   (dec_if)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: register contents and the instruction last captured.
  logic [31:0] model_rf [32];
  logic [31:0] cur_instr;

  wire [31:0] fields = {dec_if.opcode, dec_if.rs, dec_if.rt,
                        dec_if.rd, dec_if.shmnt, dec_if.funcBits};

  function automatic logic [8:0] exp_ctl(input logic [5:0] op);
    case (op)
      6'h00:   return 9'h122;
      6'h23:   return 9'h0F0;
      6'h2B:   return 9'h088;
      6'h04:   return 9'h005;
      6'h08:   return 9'h0A0;
      default: return 9'h000;
    endcase
  endfunction

  function automatic logic [31:0] exp_sext(input logic [15:0] imm);
    if (imm >= 16'h8000) return 32'hFFFF0000 + {16'h0, imm};
    return {16'h0, imm};
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] idx);
    return (idx == 5'd0) ? 32'h0 : model_rf[idx];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model_rf[i] = 32'h0;
    cur_instr = 32'h0;
  endtask

  // Drive one cycle's inputs, take the edge, update the model, sample at +1.
  task automatic drive_cycle(input logic [31:0] ins, input logic we,
                             input logic [4:0] wa, input logic [31:0] wd);
    dec_if.instruction = ins;
    dec_if.writeSig    = we;
    dec_if.finRD       = wa;
    dec_if.writeToReg  = wd;
    @(posedge Clk);
    if (Rst_n) begin
      if (we && wa != 5'd0) model_rf[wa] = wd;
      cur_instr = ins;
    end
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    Rst_n = 1'b0;
    r = $urandom();
    dec_if.instruction = r;
    dec_if.writeSig    = 1'b1;
    dec_if.finRD       = 5'd3;
    dec_if.writeToReg  = 32'hFFFFFFFF;
    model_clear();
    #1;
    checks++; if (fields !== 32'h0) begin errors++; $display("FAIL reset_fields: got %h expected %h", fields, 32'h0); end
    checks++; if (dec_if.signExtend !== 32'h0) begin errors++; $display("FAIL reset_sext: got %h expected %h", dec_if.signExtend, 32'h0); end
    checks++; if (dec_if.register1 !== 32'h0 || dec_if.register2 !== 32'h0) begin errors++; $display("FAIL reset_regs: got %h/%h expected 0/0", dec_if.register1, dec_if.register2); end
    checks++; if (dec_if.controlUnitSig !== 9'h122) begin errors++; $display("FAIL reset_ctl: got %h expected %h", dec_if.controlUnitSig, 9'h122); end
    repeat (2) @(posedge Clk);
    #1;
    checks++; if (fields !== 32'h0) begin errors++; $display("FAIL reset_hold_fields: got %h expected %h", fields, 32'h0); end
    @(negedge Clk);
    Rst_n = 1'b1;
    // Sweep every register through both read ports.
    for (int i = 0; i < 32; i++) begin
      drive_cycle({6'h00, 5'(i), 5'(31 - i), 16'h0}, 1'b0, 5'd0, 32'h0);
      checks++;
      if (dec_if.register1 !== 32'h0 || dec_if.register2 !== 32'h0) begin
        errors++;
        $display("FAIL reset_rf_r%0d: got %h/%h expected 0/0", i, dec_if.register1, dec_if.register2);
      end
    end
  endtask

  task automatic test_write_read();
    drive_cycle(32'h0, 1'b1, 5'd1, 32'h11111111);
    drive_cycle(32'h0, 1'b1, 5'd2, 32'h22222222);
    drive_cycle(32'h00221820, 1'b0, 5'd0, 32'h0);
    checks++; if (dec_if.rs !== 5'd1 || dec_if.rt !== 5'd2 || dec_if.rd !== 5'd3 || dec_if.shmnt !== 5'd0 || dec_if.funcBits !== 6'h20)
      begin errors++; $display("FAIL add_fields: got rs=%0d rt=%0d rd=%0d sh=%0d fn=%h expected 1 2 3 0 20", dec_if.rs, dec_if.rt, dec_if.rd, dec_if.shmnt, dec_if.funcBits); end
    checks++; if (dec_if.register1 !== 32'h11111111) begin errors++; $display("FAIL add_reg1: got %h expected %h", dec_if.register1, 32'h11111111); end
    checks++; if (dec_if.register2 !== 32'h22222222) begin errors++; $display("FAIL add_reg2: got %h expected %h", dec_if.register2, 32'h22222222); end
    checks++; if (dec_if.controlUnitSig !== 9'h122) begin errors++; $display("FAIL add_ctl: got %h expected %h", dec_if.controlUnitSig, 9'h122); end
    // No bypass before the edge; new value visible right after it.
    drive_cycle({6'h00, 5'd4, 5'd4, 16'h0}, 1'b0, 5'd0, 32'h0);
    dec_if.writeSig   = 1'b1;
    dec_if.finRD      = 5'd4;
    dec_if.writeToReg = 32'hCAFEF00D;
    #2;
    checks++; if (dec_if.register1 !== 32'h0) begin errors++; $display("FAIL no_bypass: got %h expected %h", dec_if.register1, 32'h0); end
    drive_cycle({6'h00, 5'd4, 5'd4, 16'h0}, 1'b1, 5'd4, 32'hCAFEF00D);
    checks++; if (dec_if.register1 !== 32'hCAFEF00D) begin errors++; $display("FAIL same_edge_write: got %h expected %h", dec_if.register1, 32'hCAFEF00D); end
  endtask

  task automatic test_sign_ext_lw();
    drive_cycle(32'h8C22FFFC, 1'b0, 5'd0, 32'h0);
    checks++; if (dec_if.opcode !== 6'h23) begin errors++; $display("FAIL lw_opcode: got %h expected %h", dec_if.opcode, 6'h23); end
    checks++; if (dec_if.signExtend !== 32'hFFFFFFFC) begin errors++; $display("FAIL lw_sext: got %h expected %h", dec_if.signExtend, 32'hFFFFFFFC); end
    checks++; if (dec_if.controlUnitSig !== 9'h0F0) begin errors++; $display("FAIL lw_ctl: got %h expected %h", dec_if.controlUnitSig, 9'h0F0); end
    drive_cycle(32'h2008007F, 1'b0, 5'd0, 32'h0);
    checks++; if (dec_if.signExtend !== 32'h0000007F) begin errors++; $display("FAIL addi_sext: got %h expected %h", dec_if.signExtend, 32'h0000007F); end
    checks++; if (dec_if.controlUnitSig !== 9'h0A0) begin errors++; $display("FAIL addi_ctl: got %h expected %h", dec_if.controlUnitSig, 9'h0A0); end
  endtask

  task automatic test_store_branch_unknown();
    logic [31:0] ins [3] = '{32'hAC220004, 32'h10220003, 32'hFC000000};
    logic [8:0]  exp [3] = '{9'h088, 9'h005, 9'h000};
    for (int i = 0; i < 3; i++) begin
      drive_cycle(ins[i], 1'b0, 5'd0, 32'h0);
      checks++;
      if (dec_if.controlUnitSig !== exp[i]) begin
        errors++;
        $display("FAIL ctl_%h: got %h expected %h", ins[i], dec_if.controlUnitSig, exp[i]);
      end
    end
  endtask

  task automatic test_r0_protect();
    drive_cycle(32'h0, 1'b1, 5'd0, 32'hDEADBEEF);
    drive_cycle(32'h0, 1'b0, 5'd0, 32'h0);
    checks++; if (dec_if.register1 !== 32'h0) begin errors++; $display("FAIL r0_write: got %h expected %h", dec_if.register1, 32'h0); end
    drive_cycle(32'h0, 1'b1, 5'd5, 32'h55AA55AA);
    drive_cycle({6'h00, 5'd5, 5'd0, 16'h0}, 1'b0, 5'd5, 32'hDEADBEEF);
    drive_cycle({6'h00, 5'd5, 5'd0, 16'h0}, 1'b0, 5'd0, 32'h0);
    checks++; if (dec_if.register1 !== 32'h55AA55AA) begin errors++; $display("FAIL r5_we_low: got %h expected %h", dec_if.register1, 32'h55AA55AA); end
  endtask

  task automatic test_async_reset();
    drive_cycle(32'h0, 1'b1, 5'd7, 32'h12345678);
    drive_cycle(32'h8CE71234, 1'b0, 5'd0, 32'h0);
    checks++; if (dec_if.register1 !== 32'h12345678) begin errors++; $display("FAIL pre_reset_r7: got %h expected %h", dec_if.register1, 32'h12345678); end
    #2;
    Rst_n = 1'b0;
    model_clear();
    #1;
    checks++; if (fields !== 32'h0) begin errors++; $display("FAIL async_fields: got %h expected %h", fields, 32'h0); end
    checks++; if (dec_if.register1 !== 32'h0 || dec_if.register2 !== 32'h0) begin errors++; $display("FAIL async_regs: got %h/%h expected 0/0", dec_if.register1, dec_if.register2); end
    checks++; if (dec_if.controlUnitSig !== 9'h122 || dec_if.signExtend !== 32'h0) begin errors++; $display("FAIL async_ctl_sext: got %h/%h expected 122/0", dec_if.controlUnitSig, dec_if.signExtend); end
    // A write presented while reset is held must be dropped.
    drive_cycle(32'hFFFFFFFF, 1'b1, 5'd9, 32'h99999999);
    @(negedge Clk);
    Rst_n = 1'b1;
    drive_cycle({6'h00, 5'd7, 5'd9, 16'h0}, 1'b0, 5'd0, 32'h0);
    checks++; if (dec_if.register1 !== 32'h0 || dec_if.register2 !== 32'h0) begin errors++; $display("FAIL post_reset_r7_r9: got %h/%h expected 0/0", dec_if.register1, dec_if.register2); end
  endtask

  task automatic test_random();
    logic [5:0]  ops [5] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08};
    logic [31:0] r, ins, wd;
    logic [5:0]  op;
    logic [4:0]  wa;
    logic        we;
    for (int n = 0; n < 400; n++) begin
      r  = $urandom();
      op = ($urandom_range(0, 5) == 5) ? 6'($urandom()) : ops[$urandom_range(0, 4)];
      ins = {op, r[25:0]};
      we = 1'($urandom_range(0, 1));
      wa = 5'($urandom());
      wd = $urandom();
      if ($urandom_range(0, 3) == 0) ins[25:21] = wa;
      drive_cycle(ins, we, wa, wd);
      checks++; if (fields !== cur_instr) begin errors++; $display("FAIL rnd_fields[%0d]: got %h expected %h", n, fields, cur_instr); end
      checks++; if (dec_if.signExtend !== exp_sext(cur_instr[15:0])) begin errors++; $display("FAIL rnd_sext[%0d]: got %h expected %h", n, dec_if.signExtend, exp_sext(cur_instr[15:0])); end
      checks++; if (dec_if.register1 !== exp_rd(cur_instr[25:21])) begin errors++; $display("FAIL rnd_reg1[%0d]: got %h expected %h", n, dec_if.register1, exp_rd(cur_instr[25:21])); end
      checks++; if (dec_if.register2 !== exp_rd(cur_instr[20:16])) begin errors++; $display("FAIL rnd_reg2[%0d]: got %h expected %h", n, dec_if.register2, exp_rd(cur_instr[20:16])); end
      checks++; if (dec_if.controlUnitSig !== exp_ctl(cur_instr[31:26])) begin errors++; $display("FAIL rnd_ctl[%0d]: got %h expected %h", n, dec_if.controlUnitSig, exp_ctl(cur_instr[31:26])); end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_sign_ext_lw();
    test_store_branch_unknown();
    test_r0_protect();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_decode_stage.md
Name: mips_decode_stage

Overview:
- MIPS instruction-decode stage: captures instruction fields into pipeline registers on each clock.
- Drives a 32x32 register file (two reads, one write), main control decode and 16→32 sign extension from the captured fields.
- Sits between instruction fetch and execute; the write-back stage writes results back through the write port.

Parameters:
- none (32-bit datapath, 32 registers, fixed MIPS encoding)

Ports:
- Clk  input  1  system clock, rising-edge active
- Rst_n  input  1  asynchronous active-low reset
- instruction  input  32  fetched instruction word
- writeToReg  input  32  write-back data
- writeSig  input  1  register-file write enable
- finRD  input  5  write-back destination register index
- signExtend  output  32  sign-extended immediate
- register1  output  32  register-file read data at index rs
- register2  output  32  register-file read data at index rt
- controlUnitSig  output  9  control bundle: [8]RegDst [7]ALUSrc [6]MemToReg [5]RegWrite [4]MemRead [3]MemWrite [2]Branch [1:0]ALUOp
- rd, rt, rs, shmnt  output  5 each  registered instruction fields [15:11], [20:16], [25:21], [10:6]
- funcBits, opcode  output  6 each  registered fields [5:0], [31:26]

Behaviour:
- Interface: one clock (Clk); reset Rst_n is asynchronous and active-low.
- Reset (Rst_n=0, immediate, no clock needed):
  - opcode, funcBits, rs, rt, rd, shmnt and the internal 16-bit immediate register clear to 0.
  - All 32 registers clear to 0.
  - Resulting outputs: signExtend=0, register1=register2=0, controlUnitSig=0x122 (opcode 0 decode).
- Field capture: each rising Clk, not in reset, all fields load from instruction. Latency is 1 cycle from instruction to fields. There is no enable; a new instruction loads every cycle.
- signExtend, register1, register2, controlUnitSig are combinational from the registered fields. They are valid in the same cycle as the fields.
- Sign extension: signExtend = {16{imm[15]}, imm}, where imm is the registered instruction[15:0].
- Control decode (opcode → controlUnitSig):
  - 0x00 R-type → 0x122 (RegDst, RegWrite, ALUOp=10)
  - 0x23 lw → 0x0F0 (ALUSrc, MemToReg, RegWrite, MemRead; ALUOp=00)
  - 0x2B sw → 0x088 (ALUSrc, MemWrite)
  - 0x04 beq → 0x005 (Branch, ALUOp=01)
  - 0x08 addi → 0x0A0 (ALUSrc, RegWrite)
  - any other opcode → 0x000; don't-cares are driven as 0.
- Register file:
  - Reads are asynchronous: register1=R[rs], register2=R[rt]. R0 always reads 0.
  - Write on rising Clk when writeSig=1 and finRD≠0: R[finRD] ← writeToReg. Writes to R0 are discarded.
  - No internal bypass: a written value is visible on the read ports after the write edge, not before.
  - Field capture and write share an edge. If the new rs equals the written register, register1 shows the new value after that edge.
- Reset asserted mid-operation overrides any pending write. Writes are blocked while Rst_n=0.

Decomposition:
- Shared package mips_pkg holds:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI
  - control-bundle bit indices CTL_REGDST…CTL_ALUOP_LSB
  - ALUOp encodings ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNC=10
- One sub-module: mips_reg_file (32x32, 2 asynchronous read ports, 1 synchronous write port, R0 hardwired zero, async active-low clear).
- Control decode and sign extension stay inline as combinational logic.

Test Plan:
- Reset: drive Rst_n=0 with arbitrary instruction → all fields 0, signExtend=0, register1=register2=0, controlUnitSig=0x122. Then read every register and confirm 0.
- Write/read: write 0x11111111 to R1 and 0x22222222 to R2. Then present 0x00221820 (add $3,$1,$2) → after 1 edge: rs=1, rt=2, rd=3, shmnt=0, funcBits=0x20, register1=0x11111111, register2=0x22222222, controlUnitSig=0x122.
- Sign extension and lw: instruction 0x8C22FFFC → opcode=0x23, signExtend=0xFFFFFFFC, controlUnitSig=0x0F0. Then 0x2008007F (addi) → signExtend=0x0000007F, controlUnitSig=0x0A0.
- Store, branch and unknown opcodes: 0xAC220004 → 0x088; 0x10220003 → 0x005; opcode 0x3F → 0x000.
- R0 protection: writeSig=1, finRD=0, writeToReg=0xDEADBEEF, then rs=0 → register1=0. Same write with writeSig=0 to R5 → R5 is unchanged.
- Asynchronous reset mid-stream: after R7 holds 0x12345678 and fields are non-zero, pulse Rst_n low between clock edges → fields and R7 read 0 immediately, without waiting for a clock.
